// File: rtl/minority_if.sv
// Vote bus for the minority voter: three vote words in, combinational and registered results out.
interface minority_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic             in_valid;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_q;
  logic             out_valid;
  logic [CNT_W-1:0] disagree_cnt;

  modport master (
    output a, b, c, in_valid,
    input  y, y_q, out_valid, disagree_cnt
  );

  modport slave (
    input  a, b, c, in_valid,
    output y, y_q, out_valid, disagree_cnt
  );
endinterface

// File: rtl/minority.sv
// Bitwise 3-input minority voter with a registered copy of the result.
// Optional disagreement counter is built only when MINORITY_STATS_EN is defined.
module minority #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic      clk,
  input  logic      rst,
  minority_if.slave bus
);

  logic [WIDTH-1:0] y_comb;
  logic [WIDTH-1:0] y_reg;
  logic             valid_reg;

  assign y_comb        = ~((bus.a & bus.b) | (bus.a & bus.c) | (bus.b & bus.c));
  assign bus.y         = y_comb;
  assign bus.y_q       = y_reg;
  assign bus.out_valid = valid_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      y_reg     <= '0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= bus.in_valid;
      if (bus.in_valid) begin
        y_reg <= y_comb;
      end
    end
  end

`ifdef MINORITY_STATS_EN
  logic             disagree;
  logic [CNT_W-1:0] cnt_reg;

  assign disagree         = |((bus.a ^ bus.b) | (bus.b ^ bus.c));
  assign bus.disagree_cnt = cnt_reg;

  // Saturate at all-ones so a long fault burst never reads back as a small count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (bus.in_valid && disagree && (cnt_reg != '1)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end
`else
  assign bus.disagree_cnt = '0;
`endif

endmodule

// File: tb/tb_minority.sv
// Directed self-checking bench for the minority voter (WIDTH=1/CNT_W=2 and WIDTH=8 instances).
module tb_minority;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  minority_if #(.WIDTH(1), .CNT_W(2))  bus1 ();
  minority_if #(.WIDTH(8), .CNT_W(16)) bus8 ();

  minority #(.WIDTH(1), .CNT_W(2))  dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  minority #(.WIDTH(8), .CNT_W(16)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus1.a = 1'b0; bus1.b = 1'b0; bus1.c = 1'b0; bus1.in_valid = 1'b1;
    bus8.a = 8'h00; bus8.b = 8'h00; bus8.c = 8'h00; bus8.in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (bus1.y !== 1'b1) begin
        errors++; $display("FAIL reset_y: got %b expected 1", bus1.y);
      end
      checks++;
      if (bus1.y_q !== 1'b0 || bus1.out_valid !== 1'b0) begin
        errors++; $display("FAIL reset_regs: got y_q=%b out_valid=%b expected 0/0", bus1.y_q, bus1.out_valid);
      end
      checks++;
      if (bus1.disagree_cnt !== 2'd0) begin
        errors++; $display("FAIL reset_cnt: got %0d expected 0", bus1.disagree_cnt);
      end
    end
    checks++;
    if (bus8.y_q !== 8'h00 || bus8.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_w8: got y_q=%h out_valid=%b expected 00/0", bus8.y_q, bus8.out_valid);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus1.y_q !== 1'b1 || bus1.out_valid !== 1'b1) begin
      errors++; $display("FAIL reset_release: got y_q=%b out_valid=%b expected 1/1", bus1.y_q, bus1.out_valid);
    end
  endtask

  task automatic test_truth_table();
    logic [7:0] tt;
    logic [2:0] abc;
    tt = 8'h17;  // abc=0,1,2,4 -> 1
    bus1.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      abc = i[2:0];
      bus1.a = abc[2]; bus1.b = abc[1]; bus1.c = abc[0];
      #5;
      checks++;
      if (bus1.y !== tt[i]) begin
        errors++; $display("FAIL truth_table abc=%b: got %b expected %b", abc, bus1.y, tt[i]);
      end
    end
    tick();
    checks++;
    if (bus1.y_q !== 1'b1 || bus1.out_valid !== 1'b0) begin
      errors++; $display("FAIL hold_no_valid: got y_q=%b out_valid=%b expected 1/0", bus1.y_q, bus1.out_valid);
    end
  endtask

  task automatic test_pulse();
    bus1.a = 1'b0; bus1.b = 1'b1; bus1.c = 1'b1; bus1.in_valid = 1'b1;
    tick();
    checks++;
    if (bus1.y_q !== 1'b0 || bus1.out_valid !== 1'b1) begin
      errors++; $display("FAIL pulse_capture: got y_q=%b out_valid=%b expected 0/1", bus1.y_q, bus1.out_valid);
    end
    bus1.a = 1'b0; bus1.b = 1'b0; bus1.c = 1'b0; bus1.in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (bus1.y_q !== 1'b0 || bus1.out_valid !== 1'b0 || bus1.y !== 1'b1) begin
        errors++; $display("FAIL pulse_hold%0d: got y=%b y_q=%b out_valid=%b expected 1/0/0", i, bus1.y, bus1.y_q, bus1.out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] va [3];
    logic [7:0] vb [3];
    logic [7:0] vc [3];
    logic [7:0] vy [3];
    va = '{8'hF0, 8'hFF, 8'h55};
    vb = '{8'hCC, 8'h00, 8'h55};
    vc = '{8'hAA, 8'h0F, 8'h55};
    vy = '{8'h17, 8'hF0, 8'hAA};
    for (int i = 0; i < 3; i++) begin
      bus8.a = va[i]; bus8.b = vb[i]; bus8.c = vc[i]; bus8.in_valid = 1'b1;
      #1;
      checks++;
      if (bus8.y !== vy[i]) begin
        errors++; $display("FAIL w8_comb%0d: got %h expected %h", i, bus8.y, vy[i]);
      end
      tick();
      checks++;
      if (bus8.y_q !== vy[i] || bus8.out_valid !== 1'b1) begin
        errors++; $display("FAIL w8_reg%0d: got y_q=%h out_valid=%b expected %h/1", i, bus8.y_q, bus8.out_valid, vy[i]);
      end
    end
    bus8.a = 8'h00; bus8.b = 8'hFF; bus8.c = 8'hFF; bus8.in_valid = 1'b0;
    tick();
    checks++;
    if (bus8.y_q !== 8'hAA || bus8.out_valid !== 1'b0) begin
      errors++; $display("FAIL w8_hold: got y_q=%h out_valid=%b expected aa/0", bus8.y_q, bus8.out_valid);
    end
  endtask

  task automatic test_counter();
    logic [2:0] pat [5];
    logic [1:0] exp_cnt [5];
    logic [1:0] sat;
    pat = '{3'b001, 3'b010, 3'b100, 3'b011, 3'b101};
`ifdef MINORITY_STATS_EN
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    sat = 2'd3;
`else
    exp_cnt = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    sat = 2'd0;
`endif
    rst = 1'b1; bus1.in_valid = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus1.a = pat[i][2]; bus1.b = pat[i][1]; bus1.c = pat[i][0]; bus1.in_valid = 1'b1;
      tick();
      checks++;
      if (bus1.disagree_cnt !== exp_cnt[i]) begin
        errors++; $display("FAIL cnt_vote%0d: got %0d expected %0d", i, bus1.disagree_cnt, exp_cnt[i]);
      end
    end
    bus1.a = 1'b1; bus1.b = 1'b1; bus1.c = 1'b1; bus1.in_valid = 1'b1;
    tick();
    checks++;
    if (bus1.disagree_cnt !== sat || bus1.y_q !== 1'b0) begin
      errors++; $display("FAIL cnt_agree: got cnt=%0d y_q=%b expected %0d/0", bus1.disagree_cnt, bus1.y_q, sat);
    end
    // Mid-stream reset drops the pending vote; the vote after release lands one cycle later.
    bus1.a = 1'b0; bus1.b = 1'b0; bus1.c = 1'b1; bus1.in_valid = 1'b1; rst = 1'b1;
    tick();
    checks++;
    if (bus1.y_q !== 1'b0 || bus1.out_valid !== 1'b0 || bus1.disagree_cnt !== 2'd0) begin
      errors++; $display("FAIL mid_reset: got y_q=%b out_valid=%b cnt=%0d expected 0/0/0", bus1.y_q, bus1.out_valid, bus1.disagree_cnt);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus1.y_q !== 1'b1 || bus1.out_valid !== 1'b1 || bus1.disagree_cnt !== exp_cnt[0]) begin
      errors++; $display("FAIL after_reset: got y_q=%b out_valid=%b cnt=%0d expected 1/1/%0d", bus1.y_q, bus1.out_valid, bus1.disagree_cnt, exp_cnt[0]);
    end
    bus1.in_valid = 1'b0;
    tick();
    checks++;
    if (bus1.disagree_cnt !== exp_cnt[0] || bus1.out_valid !== 1'b0) begin
      errors++; $display("FAIL cnt_no_valid: got cnt=%0d out_valid=%b expected %0d/0", bus1.disagree_cnt, bus1.out_valid, exp_cnt[0]);
    end
  endtask

  initial begin
    test_reset();
    test_truth_table();
    test_pulse();
    test_back_to_back();
    test_counter();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
